cpu_lsu: RTL and testbench
==========================

# cpu_lsu

Load/store unit that executes the memory commands issued by the CPU control decoder. It sits between the execute stage and the data-memory bus. It accepts `cmd` = load/store with size and sign controls, performs the request/acknowledge transaction on the bus, and returns the lane-selected, extended load data. While a transaction is outstanding it stalls the pipeline.

## Interface
- `TIMEOUT`, default 255: cycles to wait for `bus_ack` before aborting; range 1..255.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  instruction in execute stage is valid.
- `cmd`  in  2  11 load, 10 store, 01 jump, 00 other; only 11/10 act.
- `size`  in  2  00 FULL, 01 HALF, 10 BYTE, 11 illegal.
- `sx_sign`  in  1  1 = sign-extend load, 0 = zero-extend.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data, low-aligned.
- `stall`  out  1  freeze the pipeline (combinational).
- `rdata`  out  32  extended load result, registered.
- `rdata_valid`  out  1  one-cycle pulse: `rdata` valid / store complete.
- `misalign`  out  1  one-cycle pulse: rejected request.
- `bus_err`  out  1  one-cycle pulse: timeout abort.
- `bus_req`  out  1  bus request, held until ack.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word address, `{addr[31:2],2'b00}`.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  replicated store data.
- `bus_ack`  in  1  transaction complete; `bus_rdata` valid in the same cycle.
- `bus_rdata`  in  32  read word.

## Operation
- FSM states: IDLE, BUS, RESP.
- **IDLE**
  - Memory request = `req_valid` & `cmd[1]`.
  - Legal and aligned: latch `addr`, `size`, `sx_sign`, `we=~cmd[0]`, `be`, steered wdata; go to BUS.
  - Illegal (`size`=11, HALF with `addr[0]`=1, FULL with `addr[1:0]`≠0): pulse `misalign` next cycle; no bus activity; stay IDLE.
- **BUS**
  - `bus_req`=1 and bus outputs stable.
  - On `bus_ack`: for loads, register the extended `bus_rdata` into `rdata`; go to RESP.
  - Timeout counter increments each BUS cycle without ack. When the count reaches `TIMEOUT`, drop the request, pulse `bus_err`, leave `rdata` unchanged, and go to RESP.
- **RESP**
  - `rdata_valid`=1, except after a timeout.
  - `req_valid` is ignored, because the stalled instruction is still presented. Always returns to IDLE.
- Byte enables (little-endian):
  - FULL = 1111.
  - HALF = 0011 << 2·`addr[1]`.
  - BYTE = 0001 << `addr[1:0]`.
- Write data:
  - FULL as is.
  - HALF = {wdata[15:0], wdata[15:0]}.
  - BYTE = wdata[7:0] ×4.
- Load extract:
  - FULL word.
  - HALF = lane `addr[1]`.
  - BYTE = lane `addr[1:0]`.
  - Extended to 32 bits with bit 15/7 when `sx_sign`=1, with zeros otherwise.
- `stall` = (IDLE & legal memory request) | BUS.
- `bus_ack` outside BUS is ignored.

## Timing
- Reset: state IDLE; counter 0; `rdata`, `rdata_valid`, `misalign`, `bus_err`, `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata` all 0.
- Latency with zero-wait ack:
  - Cycle 0: accept, `stall`=1.
  - Cycle 1: `bus_req`=1, ack arrives, `stall`=1.
  - Cycle 2: `rdata_valid`=1, `stall`=0.
- Each wait-state cycle adds one cycle.
- Back-to-back accesses: a new request is accepted no earlier than the cycle after RESP, giving a minimum 3-cycle spacing.
- `misalign` is asserted exactly one cycle after the request cycle and never stalls.
- Timeout: with no ack, `bus_req` is high for exactly `TIMEOUT` cycles, then `bus_err` pulses during RESP.
- `rst` in BUS or RESP: the next cycle is IDLE with all outputs at reset values. A late `bus_ack` is ignored.

## Structure
- Shared package `cpu_pkg`:
  - cmd encodings (LW_CMD, ST_CMD, JMP_CMD, OTHER).
  - size encodings (FULL, HALF, BYTE, UPPER).
  - SIGN/UNSIGN.
  - LSU state enum.
- These are the same constants used by the control decoder.
- Sub-module `cpu_lsu_align` (combinational):
  - Store side: `addr[1:0]`, `size` → `bus_be` and replicated wdata.
  - Load side: `bus_rdata`, `addr[1:0]`, `size`, `sx_sign` → extended `rdata`.
- The FSM, counter and registers live in `cpu_lsu`.

## Test plan
- LB, sign-extended: `addr`=0x1003, `bus_rdata`=0x80FF_1234, ack in first BUS cycle → `bus_be`=1000, `bus_addr`=0x1000, `rdata`=0xFFFF_FF80 with `rdata_valid` in cycle 2.
- LHU: `addr`=0x2002, `bus_rdata`=0xBEEF_0000, 2 wait states → `bus_be`=1100, `rdata`=0x0000_BEEF, `stall` high for 4 cycles.
- Store byte: `wdata`=0x0000_00A5, `addr`=0x11 → `bus_we`=1, `bus_be`=0010, `bus_wdata`=0xA5A5_A5A5, then `rdata_valid` pulse.
- Misaligned LW at 0x6, and HALF at 0x1 → `misalign` pulse, `bus_req` never rises, `stall` stays 0.
- `TIMEOUT`=4, no ack → `bus_req` high 4 cycles, `bus_err` pulse, no `rdata_valid`, back to IDLE. A late ack is ignored.
- `rst` asserted in the 2nd BUS cycle → outputs zero next cycle; a following legal LW completes normally. `cmd`=01/00 with `req_valid` → no stall, no bus activity.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: command and size encodings used by the control
// decoder and the load/store unit, plus the LSU state type.
package cpu_pkg;

  typedef enum logic [1:0] {
    OTHER   = 2'b00,
    JMP_CMD = 2'b01,
    ST_CMD  = 2'b10,
    LW_CMD  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    FULL  = 2'b00,
    HALF  = 2'b01,
    BYTE  = 2'b10,
    UPPER = 2'b11
  } size_e;

  localparam logic SIGN   = 1'b1;
  localparam logic UNSIGN = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } lsu_state_e;

  // A request is legal when its size is defined and the address is naturally
  // aligned for that size (bytes are always aligned).
  function automatic logic lsuLegal(input logic [1:0] sizeIn, input logic [1:0] addrLo);
    logic ok;
    ok = 1'b1;
    if (sizeIn == UPPER) ok = 1'b0;
    if ((sizeIn == HALF) && addrLo[0]) ok = 1'b0;
    if ((sizeIn == FULL) && (addrLo != 2'b00)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/cpu_lsu_align.sv
// Lane steering for the load/store unit: byte enables and replicated write
// data on the store side, lane selection and sign/zero extension on the load
// side. Purely combinational.
module cpu_lsu_align
  import cpu_pkg::*;
(
  input  logic [1:0]  stAddr_i,
  input  logic [1:0]  stSize_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdataRep_o,
  input  logic [1:0]  ldAddr_i,
  input  logic [1:0]  ldSize_i,
  input  logic        ldSign_i,
  input  logic [31:0] busRdata_i,
  output logic [31:0] rdataExt_o
);

  // Store side: the word lanes to write and the store data copied into every lane.
  always_comb begin
    be_o       = 4'b0000;
    wdataRep_o = 32'h0;
    case (stSize_i)
      FULL: begin
        be_o       = 4'b1111;
        wdataRep_o = wdata_i;
      end
      HALF: begin
        be_o       = stAddr_i[1] ? 4'b1100 : 4'b0011;
        wdataRep_o = {wdata_i[15:0], wdata_i[15:0]};
      end
      BYTE: begin
        be_o       = 4'b0001 << stAddr_i;
        wdataRep_o = {4{wdata_i[7:0]}};
      end
      default: begin
        be_o       = 4'b0000;
        wdataRep_o = 32'h0;
      end
    endcase
  end

  // Load side: pick the addressed lane and extend it to a full word.
  always_comb begin
    logic [15:0] halfLane;
    logic [7:0]  byteLane;
    halfLane   = ldAddr_i[1] ? busRdata_i[31:16] : busRdata_i[15:0];
    byteLane   = busRdata_i[{ldAddr_i, 3'b000} +: 8];
    rdataExt_o = busRdata_i;
    case (ldSize_i)
      HALF:    rdataExt_o = {{16{ldSign_i & halfLane[15]}}, halfLane};
      BYTE:    rdataExt_o = {{24{ldSign_i & byteLane[7]}}, byteLane};
      default: rdataExt_o = busRdata_i;
    endcase
  end

endmodule

// File: rtl/cpu_lsu.sv
// Load/store unit: accepts load/store commands from execute, runs one
// request/acknowledge transaction on the data bus with a timeout, and
// returns the extended load data. Stalls the pipeline while busy.
module cpu_lsu
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  cmd,
  input  logic [1:0]  size,
  input  logic        sx_sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  lsu_state_e  state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic [1:0]  addrLo_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [31:0] rdata_q;
  logic        rdataValid_q;
  logic        misalign_q;
  logic        busErr_q;
  logic        busReq_q;
  logic        busWe_q;
  logic [31:0] busAddr_q;
  logic [3:0]  busBe_q;
  logic [31:0] busWdata_q;

  logic        memReq;
  logic        legal;
  logic        accept;
  logic [3:0]  beNext;
  logic [31:0] wdataNext;
  logic [31:0] loadData;

  // Store steering comes from the live request; load extraction from the
  // fields latched when the request was accepted.
  cpu_lsu_align u_align (
    .stAddr_i   (addr[1:0]),
    .stSize_i   (size),
    .wdata_i    (wdata),
    .be_o       (beNext),
    .wdataRep_o (wdataNext),
    .ldAddr_i   (addrLo_q),
    .ldSize_i   (size_q),
    .ldSign_i   (sign_q),
    .busRdata_i (bus_rdata),
    .rdataExt_o (loadData)
  );

  // Request qualification and the combinational pipeline stall.
  always_comb begin
    memReq = req_valid & cmd[1];
    legal  = lsuLegal(size, addr[1:0]);
    accept = (state_q == IDLE) & memReq & legal;
    stall  = accept | (state_q == BUS);
    cnt_d  = cnt_q + 8'd1;
  end

  // Transaction FSM with timeout counter; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      addrLo_q     <= 2'b00;
      size_q       <= 2'b00;
      sign_q       <= 1'b0;
      rdata_q      <= 32'h0;
      rdataValid_q <= 1'b0;
      misalign_q   <= 1'b0;
      busErr_q     <= 1'b0;
      busReq_q     <= 1'b0;
      busWe_q      <= 1'b0;
      busAddr_q    <= 32'h0;
      busBe_q      <= 4'b0000;
      busWdata_q   <= 32'h0;
    end else begin
      rdataValid_q <= 1'b0;
      misalign_q   <= 1'b0;
      busErr_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (memReq) begin
            if (legal) begin
              addrLo_q   <= addr[1:0];
              size_q     <= size;
              sign_q     <= sx_sign;
              busWe_q    <= ~cmd[0];
              busAddr_q  <= {addr[31:2], 2'b00};
              busBe_q    <= beNext;
              busWdata_q <= wdataNext;
              busReq_q   <= 1'b1;
              cnt_q      <= 8'd0;
              state_q    <= BUS;
            end else begin
              misalign_q <= 1'b1;
            end
          end
        end
        BUS: begin
          if (bus_ack) begin
            if (!busWe_q) rdata_q <= loadData;
            busReq_q     <= 1'b0;
            rdataValid_q <= 1'b1;
            cnt_q        <= 8'd0;
            state_q      <= RESP;
          end else if (cnt_d == TIMEOUT_CNT) begin
            busReq_q <= 1'b0;
            busErr_q <= 1'b1;
            cnt_q    <= 8'd0;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdataValid_q;
  assign misalign    = misalign_q;
  assign bus_err     = busErr_q;
  assign bus_req     = busReq_q;
  assign bus_we      = busWe_q;
  assign bus_addr    = busAddr_q;
  assign bus_be      = busBe_q;
  assign bus_wdata   = busWdata_q;

endmodule

// File: tb/tb_cpu_lsu.sv
// Directed testbench for cpu_lsu: loads, stores, misaligned requests,
// timeout abort, reset mid-transaction and non-memory commands.
module tb_cpu_lsu;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [1:0]  cmd;
  logic [1:0]  size;
  logic        sx_sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int compareCount;
  int mismatchCount;
  int stallCount;
  int reqCount;
  int validCount;

  cpu_lsu #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .cmd         (cmd),
    .size        (size),
    .sx_sign     (sx_sign),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .misalign    (misalign),
    .bus_err     (bus_err),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present a request on the execute-stage inputs.
  task automatic applyStimulus(input logic v, input logic [1:0] c, input logic [1:0] s,
                               input logic sg, input logic [31:0] a, input logic [31:0] wd);
    req_valid = v;
    cmd       = c;
    size      = s;
    sx_sign   = sg;
    addr      = a;
    wdata     = wd;
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge, where outputs are sampled.
  task automatic sampleEdge();
    @(negedge clk);
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst       = 1'b1;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    applyStimulus(1'b0, OTHER, FULL, UNSIGN, 32'h0, 32'h0);
    nextCycle();
    nextCycle();
    sampleEdge();
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_flags", {26'h0, rdata_valid, misalign, bus_err, bus_req, bus_we, stall}, 32'h0);
    checkOutput("rst_bus_addr", bus_addr, 32'h0);
    checkOutput("rst_bus_be", {28'h0, bus_be}, 32'h0);
    checkOutput("rst_bus_wdata", bus_wdata, 32'h0);

    // LB sign-extended, zero-wait ack
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b1, LW_CMD, BYTE, SIGN, 32'h0000_1003, 32'h0);
    sampleEdge();
    checkOutput("lb_c0_stall", {31'h0, stall}, 32'h1);
    nextCycle();
    bus_ack   = 1'b1;
    bus_rdata = 32'h80FF_1234;
    sampleEdge();
    checkOutput("lb_c1_req", {31'h0, bus_req}, 32'h1);
    checkOutput("lb_c1_be", {28'h0, bus_be}, 32'h8);
    checkOutput("lb_c1_addr", bus_addr, 32'h0000_1000);
    checkOutput("lb_c1_we_stall", {30'h0, bus_we, stall}, 32'h1);
    nextCycle();
    bus_ack = 1'b0;
    applyStimulus(1'b0, OTHER, FULL, UNSIGN, 32'h0, 32'h0);
    sampleEdge();
    checkOutput("lb_c2_valid_stall", {30'h0, rdata_valid, stall}, 32'h2);
    checkOutput("lb_c2_rdata", rdata, 32'hFFFF_FF80);

    // LHU with two wait states: stall high for four cycles
    stallCount = 0;
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      if (i == 0) applyStimulus(1'b1, LW_CMD, HALF, UNSIGN, 32'h0000_2002, 32'h0);
      if (i == 4) applyStimulus(1'b0, OTHER, FULL, UNSIGN, 32'h0, 32'h0);
      bus_ack   = (i == 3);
      bus_rdata = 32'hBEEF_0000;
      sampleEdge();
      stallCount += int'(stall);
      if (i == 1) checkOutput("lhu_be", {28'h0, bus_be}, 32'hC);
      if (i == 3) checkOutput("lhu_valid_early", {31'h0, rdata_valid}, 32'h0);
      if (i == 4) checkOutput("lhu_valid", {31'h0, rdata_valid}, 32'h1);
    end
    bus_ack = 1'b0;
    checkOutput("lhu_rdata", rdata, 32'h0000_BEEF);
    checkOutput("lhu_stall_cycles", 32'(stallCount), 32'd4);

    // Store byte
    nextCycle();
    applyStimulus(1'b1, ST_CMD, BYTE, UNSIGN, 32'h0000_0011, 32'h0000_00A5);
    nextCycle();
    bus_ack = 1'b1;
    sampleEdge();
    checkOutput("sb_we_req", {30'h0, bus_we, bus_req}, 32'h3);
    checkOutput("sb_be", {28'h0, bus_be}, 32'h2);
    checkOutput("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
    checkOutput("sb_addr", bus_addr, 32'h0000_0010);
    nextCycle();
    bus_ack = 1'b0;
    applyStimulus(1'b0, OTHER, FULL, UNSIGN, 32'h0, 32'h0);
    sampleEdge();
    checkOutput("sb_valid", {31'h0, rdata_valid}, 32'h1);
    checkOutput("sb_rdata_kept", rdata, 32'h0000_BEEF);

    // Misaligned LW at 0x6, then HALF at 0x1
    for (int k = 0; k < 2; k++) begin
      nextCycle();
      if (k == 0) applyStimulus(1'b1, LW_CMD, FULL, UNSIGN, 32'h0000_0006, 32'h0);
      else        applyStimulus(1'b1, LW_CMD, HALF, SIGN, 32'h0000_0001, 32'h0);
      sampleEdge();
      checkOutput("mis_c0_stall", {31'h0, stall}, 32'h0);
      nextCycle();
      applyStimulus(1'b0, OTHER, FULL, UNSIGN, 32'h0, 32'h0);
      sampleEdge();
      checkOutput("mis_c1_pulse_req_stall", {29'h0, misalign, bus_req, stall}, 32'h4);
      nextCycle();
      sampleEdge();
      checkOutput("mis_c2_pulse_req", {30'h0, misalign, bus_req}, 32'h0);
    end

    // Timeout with no ack, late ack in RESP ignored
    reqCount   = 0;
    validCount = 0;
    for (int i = 0; i < 7; i++) begin
      nextCycle();
      if (i == 0) applyStimulus(1'b1, LW_CMD, FULL, UNSIGN, 32'h0000_0040, 32'h0);
      if (i == 5) applyStimulus(1'b0, OTHER, FULL, UNSIGN, 32'h0, 32'h0);
      bus_ack   = (i == 5);
      bus_rdata = 32'hDEAD_BEEF;
      sampleEdge();
      reqCount   += int'(bus_req);
      validCount += int'(rdata_valid);
      if (i == 5) checkOutput("to_err_pulse", {31'h0, bus_err}, 32'h1);
      if (i == 6) checkOutput("to_err_idle", {30'h0, bus_err, stall}, 32'h0);
    end
    bus_ack = 1'b0;
    checkOutput("to_req_cycles", 32'(reqCount), 32'd4);
    checkOutput("to_no_valid", 32'(validCount), 32'd0);
    checkOutput("to_rdata_kept", rdata, 32'h0000_BEEF);

    // Reset in second BUS cycle, then a normal LW
    nextCycle();
    applyStimulus(1'b1, LW_CMD, FULL, UNSIGN, 32'h0000_0080, 32'h0);
    nextCycle();
    nextCycle();
    rst = 1'b1;
    sampleEdge();
    checkOutput("rstbus_req_before", {31'h0, bus_req}, 32'h1);
    nextCycle();
    rst     = 1'b0;
    bus_ack = 1'b1;
    applyStimulus(1'b0, OTHER, FULL, UNSIGN, 32'h0, 32'h0);
    sampleEdge();
    checkOutput("rstbus_flags", {26'h0, rdata_valid, misalign, bus_err, bus_req, bus_we, stall}, 32'h0);
    checkOutput("rstbus_addr", bus_addr, 32'h0);
    checkOutput("rstbus_rdata", rdata, 32'h0);
    nextCycle();
    bus_ack = 1'b0;
    sampleEdge();
    checkOutput("rstbus_late_ack", {31'h0, rdata_valid}, 32'h0);
    nextCycle();
    applyStimulus(1'b1, LW_CMD, FULL, UNSIGN, 32'h0000_0084, 32'h0);
    nextCycle();
    bus_ack   = 1'b1;
    bus_rdata = 32'h1234_5678;
    sampleEdge();
    checkOutput("lw_after_rst_addr", bus_addr, 32'h0000_0084);
    nextCycle();
    bus_ack = 1'b0;
    applyStimulus(1'b0, OTHER, FULL, UNSIGN, 32'h0, 32'h0);
    sampleEdge();
    checkOutput("lw_after_rst_valid", {31'h0, rdata_valid}, 32'h1);
    checkOutput("lw_after_rst_rdata", rdata, 32'h1234_5678);

    // Non-memory commands: no stall, no bus activity
    for (int k = 0; k < 2; k++) begin
      nextCycle();
      applyStimulus(1'b1, (k == 0) ? JMP_CMD : OTHER, FULL, UNSIGN, 32'h0000_0100, 32'h0);
      sampleEdge();
      checkOutput("nonmem_stall", {31'h0, stall}, 32'h0);
      nextCycle();
      sampleEdge();
      checkOutput("nonmem_bus", {29'h0, bus_req, misalign, stall}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
